// File: rtl/tlp_tx_arbiter.sv
// tlp_tx_arbiter: packet-level round-robin arbiter sharing one registered valid/ready TLP stream
module tlp_tx_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int DATA_WIDTH = 32,
    localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0]            req_last,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          out_valid,
    output logic                          out_last,
    output logic [DATA_WIDTH-1:0]         out_data,
    input  logic                          out_ready,
    output logic [ID_W-1:0]               out_grant_id,
    output logic                          busy
);
    typedef enum logic {IDLE, LOCKED} state_t;
    state_t state, state_nxt;
    logic [ID_W-1:0] last_grant, winner, idx;
    logic [DATA_WIDTH-1:0] data_arr [NUM_REQ];
    logic any_valid, load, accept, sel_valid, sel_last;
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_slice
        assign data_arr[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
    assign sel_valid = req_valid[out_grant_id];
    assign sel_last  = req_last[out_grant_id];
    assign load      = !out_valid || out_ready;
    assign accept    = (state == LOCKED) && load && sel_valid;
    assign any_valid = |req_valid;
    // first valid source after last_grant wins; descending scan lets the nearest one override
    always_comb begin
        winner = last_grant;
        idx = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = ID_W'((int'(last_grant) + k) % NUM_REQ);
            if (req_valid[idx]) winner = idx;
        end
    end
    // state register; reset aborts any packet in flight
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else state <= state_nxt;
    end
    // lock on any request, release once the last beat is taken
    always_comb begin
        state_nxt = (state == IDLE) ? (any_valid ? LOCKED : IDLE)
                                    : ((accept && sel_last) ? IDLE : LOCKED);
    end
    // only the granted source sees ready, and only when the output stage can load
    always_comb begin
        req_ready = (state == LOCKED && load) ? (NUM_REQ'(1) << out_grant_id) : '0;
        busy = (state == LOCKED);
    end
    // output stage and grant bookkeeping; the last beat is held across arbitration
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid    <= 1'b0;
            out_last     <= 1'b0;
            out_data     <= '0;
            out_grant_id <= '0;
            last_grant   <= ID_W'(NUM_REQ - 1);
        end else if (state == IDLE) begin
            if (out_ready) out_valid <= 1'b0;
            if (any_valid) begin
                out_grant_id <= winner;
                last_grant   <= winner;
            end
        end else if (load) begin
            out_valid <= sel_valid;
            if (sel_valid) begin
                out_data <= data_arr[out_grant_id];
                out_last <= sel_last;
            end
        end
    end
endmodule

// File: tb/tb_tlp_tx_arbiter.sv
// tb_tlp_tx_arbiter: directed scenario bench for the TLP TX round-robin arbiter
module tb_tlp_tx_arbiter;
    localparam int N = 3;
    localparam int W = 32;
    localparam int IW = 2;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic [N-1:0] req_valid, req_last, req_ready;
    logic [N*W-1:0] req_data;
    logic out_valid, out_last, out_ready, busy;
    logic [W-1:0] out_data;
    logic [IW-1:0] out_grant_id;
    int checks = 0;
    int errors = 0;
    logic [W:0] q [N][$];
    logic [N-1:0] en;
    logic rdy;
    logic [W-1:0] got_d [$];
    logic got_l [$];

    tlp_tx_arbiter #(.NUM_REQ(N), .DATA_WIDTH(W)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_last(req_last), .req_data(req_data),
        .req_ready(req_ready), .out_valid(out_valid), .out_last(out_last), .out_data(out_data),
        .out_ready(out_ready), .out_grant_id(out_grant_id), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            req_valid[i] = en[i] && q[i].size() > 0;
            req_data[i*W +: W] = q[i].size() > 0 ? q[i][0][W-1:0] : '0;
            req_last[i] = q[i].size() > 0 ? q[i][0][W] : 1'b0;
        end
        out_ready = rdy;
    endtask

    task automatic step();
        for (int i = 0; i < N; i++) if (req_valid[i] && req_ready[i]) q[i].delete(0);
        if (out_valid && out_ready) begin
            got_d.push_back(out_data);
            got_l.push_back(out_last);
        end
        @(posedge clk);
        #1;
        drive();
        #4;
    endtask

    task automatic load(input int s, input int n, input logic [W-1:0] base);
        for (int b = 0; b < n; b++) q[s].push_back({b == n - 1, base + W'(b)});
    endtask

    task automatic apply_reset();
        for (int i = 0; i < N; i++) q[i].delete();
        en = '0;
        rdy = 1'b1;
        drive();
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        got_d.delete();
        got_l.delete();
    endtask

    task automatic test_reset();
        for (int i = 0; i < N; i++) q[i].delete();
        en = '0;
        rdy = 1'b1;
        drive();
        #12;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b exp 0", out_valid); end
        checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL rst_out_last got %b exp 0", out_last); end
        checks++; if (out_data !== '0) begin errors++; $display("FAIL rst_out_data got %h exp 0", out_data); end
        checks++; if (out_grant_id !== '0) begin errors++; $display("FAIL rst_grant_id got %0d exp 0", out_grant_id); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", busy); end
        checks++; if (req_ready !== '0) begin errors++; $display("FAIL rst_req_ready got %b exp 000", req_ready); end
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic test_single();
        int e_ov [6] = '{0, 0, 1, 1, 1, 0};
        int e_ol [6] = '{0, 0, 0, 0, 1, 0};
        int e_bz [6] = '{0, 1, 1, 1, 0, 0};
        int e_rr [6] = '{0, 2, 2, 2, 0, 0};
        logic [W-1:0] e_od [6] = '{0, 0, 32'hA1, 32'hA2, 32'hA3, 0};
        apply_reset();
        load(1, 3, 32'hA1);
        en = '1;
        for (int c = 0; c < 6; c++) begin
            step();
            checks++; if (out_valid !== 1'(e_ov[c])) begin errors++; $display("FAIL single_valid c%0d got %b exp %0d", c, out_valid, e_ov[c]); end
            checks++; if (busy !== 1'(e_bz[c])) begin errors++; $display("FAIL single_busy c%0d got %b exp %0d", c, busy, e_bz[c]); end
            checks++; if (req_ready !== 3'(e_rr[c])) begin errors++; $display("FAIL single_ready c%0d got %b exp %0d", c, req_ready, e_rr[c]); end
            if (c >= 1) begin
                checks++; if (out_grant_id !== 2'd1) begin errors++; $display("FAIL single_grant c%0d got %0d exp 1", c, out_grant_id); end
            end
            if (e_ov[c] == 1) begin
                checks++; if (out_data !== e_od[c]) begin errors++; $display("FAIL single_data c%0d got %h exp %h", c, out_data, e_od[c]); end
                checks++; if (out_last !== 1'(e_ol[c])) begin errors++; $display("FAIL single_last c%0d got %b exp %0d", c, out_last, e_ol[c]); end
            end
        end
    endtask

    task automatic test_round_robin();
        apply_reset();
        for (int s = 0; s < N; s++) for (int p = 0; p < 2; p++) load(s, 2, W'(32'h100 * s + 32'h10 * p));
        en = '1;
        for (int c = 0; c < 60 && got_d.size() < 12; c++) begin
            step();
            checks++; if ($countones(req_ready) > 1) begin errors++; $display("FAIL rr_onehot c%0d got %b exp at most one bit", c, req_ready); end
            if (req_ready != '0) begin
                checks++; if (req_ready !== (3'b1 << out_grant_id)) begin errors++; $display("FAIL rr_ready_grant c%0d got %b exp bit %0d", c, req_ready, out_grant_id); end
            end
        end
        checks++; if (got_d.size() !== 12) begin errors++; $display("FAIL rr_count got %0d exp 12", got_d.size()); end
        for (int j = 0; j < got_d.size() && j < 12; j++) begin
            checks++;
            if (got_d[j] !== W'(32'h100 * ((j / 2) % 3) + 32'h10 * (j / 6) + (j % 2)) || got_l[j] !== 1'(j % 2)) begin
                errors++;
                $display("FAIL rr_order beat%0d got %h/%b exp %h/%0d", j, got_d[j], got_l[j], W'(32'h100 * ((j / 2) % 3) + 32'h10 * (j / 6) + (j % 2)), j % 2);
            end
        end
    endtask

    task automatic test_backpressure();
        int e_ov [11] = '{0, 0, 1, 1, 1, 1, 1, 1, 1, 1, 0};
        int e_rr [11] = '{0, 1, 1, 0, 0, 0, 0, 1, 1, 0, 0};
        int e_bz [11] = '{0, 1, 1, 1, 1, 1, 1, 1, 1, 0, 0};
        logic [W-1:0] e_od [11] = '{0, 0, 32'hB0, 32'hB1, 32'hB1, 32'hB1, 32'hB1, 32'hB1, 32'hB2, 32'hB3, 0};
        apply_reset();
        load(0, 4, 32'hB0);
        en = '1;
        for (int c = 0; c < 11; c++) begin
            rdy = (c >= 3 && c <= 6) ? 1'b0 : 1'b1;
            step();
            checks++; if (out_valid !== 1'(e_ov[c])) begin errors++; $display("FAIL bp_valid c%0d got %b exp %0d", c, out_valid, e_ov[c]); end
            checks++; if (req_ready !== 3'(e_rr[c])) begin errors++; $display("FAIL bp_ready c%0d got %b exp %0d", c, req_ready, e_rr[c]); end
            checks++; if (busy !== 1'(e_bz[c])) begin errors++; $display("FAIL bp_busy c%0d got %b exp %0d", c, busy, e_bz[c]); end
            if (e_ov[c] == 1) begin
                checks++; if (out_data !== e_od[c]) begin errors++; $display("FAIL bp_data c%0d got %h exp %h", c, out_data, e_od[c]); end
            end
        end
        checks++; if (got_d.size() !== 4) begin errors++; $display("FAIL bp_count got %0d exp 4", got_d.size()); end
        for (int j = 0; j < got_d.size() && j < 4; j++) begin
            checks++; if (got_d[j] !== 32'hB0 + W'(j)) begin errors++; $display("FAIL bp_seq beat%0d got %h exp %h", j, got_d[j], 32'hB0 + W'(j)); end
        end
    endtask

    task automatic test_drop();
        int e_ov [11] = '{0, 0, 1, 1, 0, 0, 1, 1, 0, 1, 0};
        int e_rr [11] = '{0, 4, 4, 4, 4, 4, 4, 0, 1, 0, 0};
        int e_bz [11] = '{0, 1, 1, 1, 1, 1, 1, 0, 1, 0, 0};
        int e_gi [11] = '{0, 2, 2, 2, 2, 2, 2, 2, 0, 0, 0};
        int e_ol [11] = '{0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0};
        logic [W-1:0] e_od [11] = '{0, 0, 32'hC0, 32'hC1, 0, 0, 32'hC2, 32'hC3, 0, 32'hD0, 0};
        logic [W-1:0] e_seq [5] = '{32'hC0, 32'hC1, 32'hC2, 32'hC3, 32'hD0};
        apply_reset();
        load(2, 4, 32'hC0);
        load(0, 1, 32'hD0);
        for (int c = 0; c < 11; c++) begin
            en = {!(c == 3 || c == 4), 1'b0, c >= 1};
            step();
            checks++; if (out_valid !== 1'(e_ov[c])) begin errors++; $display("FAIL drop_valid c%0d got %b exp %0d", c, out_valid, e_ov[c]); end
            checks++; if (req_ready !== 3'(e_rr[c])) begin errors++; $display("FAIL drop_ready c%0d got %b exp %0d", c, req_ready, e_rr[c]); end
            checks++; if (busy !== 1'(e_bz[c])) begin errors++; $display("FAIL drop_busy c%0d got %b exp %0d", c, busy, e_bz[c]); end
            checks++; if (out_grant_id !== 2'(e_gi[c])) begin errors++; $display("FAIL drop_grant c%0d got %0d exp %0d", c, out_grant_id, e_gi[c]); end
            if (e_ov[c] == 1) begin
                checks++; if (out_data !== e_od[c] || out_last !== 1'(e_ol[c])) begin errors++; $display("FAIL drop_data c%0d got %h/%b exp %h/%0d", c, out_data, out_last, e_od[c], e_ol[c]); end
            end
        end
        checks++; if (got_d.size() !== 5) begin errors++; $display("FAIL drop_count got %0d exp 5", got_d.size()); end
        for (int j = 0; j < got_d.size() && j < 5; j++) begin
            checks++; if (got_d[j] !== e_seq[j]) begin errors++; $display("FAIL drop_seq beat%0d got %h exp %h", j, got_d[j], e_seq[j]); end
        end
    endtask

    task automatic test_back_to_back();
        int e_ov [5] = '{0, 0, 1, 0, 1};
        int e_bz [5] = '{0, 1, 0, 1, 0};
        int e_rr [5] = '{0, 1, 0, 2, 0};
        logic [W-1:0] e_od [5] = '{0, 0, 32'hE0, 0, 32'hE1};
        apply_reset();
        load(0, 1, 32'hE0);
        load(1, 1, 32'hE1);
        en = '1;
        for (int c = 0; c < 5; c++) begin
            step();
            checks++; if (out_valid !== 1'(e_ov[c])) begin errors++; $display("FAIL b2b_valid c%0d got %b exp %0d", c, out_valid, e_ov[c]); end
            checks++; if (busy !== 1'(e_bz[c])) begin errors++; $display("FAIL b2b_busy c%0d got %b exp %0d", c, busy, e_bz[c]); end
            checks++; if (req_ready !== 3'(e_rr[c])) begin errors++; $display("FAIL b2b_ready c%0d got %b exp %0d", c, req_ready, e_rr[c]); end
            if (e_ov[c] == 1) begin
                checks++; if (out_data !== e_od[c] || out_last !== 1'b1) begin errors++; $display("FAIL b2b_data c%0d got %h/%b exp %h/1", c, out_data, out_last, e_od[c]); end
            end
        end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        load(1, 4, 32'hF0);
        en = '1;
        for (int c = 0; c < 4; c++) step();
        checks++; if (out_valid !== 1'b1 || out_data !== 32'hF1) begin errors++; $display("FAIL mid_pre got %b/%h exp 1/f1", out_valid, out_data); end
        #1;
        rst = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_valid_drop got %b exp 0", out_valid); end
        checks++; if (busy !== 1'b0 || req_ready !== '0) begin errors++; $display("FAIL mid_idle got %b/%b exp 0/000", busy, req_ready); end
        for (int i = 0; i < N; i++) q[i].delete();
        load(0, 1, 32'h60);
        load(1, 1, 32'h61);
        drive();
        @(posedge clk);
        #4;
        rst = 1'b1;
        step();
        checks++; if (out_grant_id !== 2'd0 || req_ready !== 3'b001) begin errors++; $display("FAIL mid_first_grant got %0d/%b exp 0/001", out_grant_id, req_ready); end
        step();
        checks++; if (out_valid !== 1'b1 || out_data !== 32'h60) begin errors++; $display("FAIL mid_first_data got %b/%h exp 1/60", out_valid, out_data); end
        step();
        checks++; if (out_grant_id !== 2'd1 || req_ready !== 3'b010) begin errors++; $display("FAIL mid_second_grant got %0d/%b exp 1/010", out_grant_id, req_ready); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_drop();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
